// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Purpose  : Push handshake between the bus adapter and the UART TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              req;
    logic              req_ack;

    modport master (output tx_data, output req, input req_ack);
    modport slave  (input tx_data, input req, output req_ack);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : UART transmitter fed by a DEPTH-entry FIFO, back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int BAUD_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_tx_fifo_if.slave           bus,
    input  logic [1:0]              stop,
    input  logic                    parity_en,
    input  logic                    parity_odd,
    input  logic [BAUD_W-1:0]       baudrate,
    output logic                    uart_tx,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL     = (c_AW+1)'(DEPTH);
    localparam logic [3:0]      c_LAST_BIT = 4'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state, w_state;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]       r_count, w_count;
    logic                r_req_ack;
    logic [DATA_W-1:0]   r_shift, w_shift;
    logic [BAUD_W-1:0]   r_timer, w_timer, r_bmax, w_bmax;
    logic [3:0]          r_bit, w_bit;
    logic [1:0]          r_nstop, w_nstop;
    logic                r_par_en, w_par_en, r_par_bit, w_par_bit;
    logic                r_tx, w_tx, r_busy, w_busy;
    logic                w_push, w_pop, w_start, w_tick;
    logic [DATA_W-1:0]   w_head;

    // Push legality looks only at registered state, so a held req is never double-pushed.
    assign w_push = bus.req & ~r_req_ack & (r_count < c_FULL);
    assign w_head = r_mem[r_rd_ptr];
    assign w_tick = (r_timer == r_bmax);

    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_bmax    = r_bmax;
        w_bit     = r_bit;
        w_nstop   = r_nstop;
        w_par_en  = r_par_en;
        w_par_bit = r_par_bit;
        w_tx      = r_tx;
        w_start   = 1'b0;
        w_pop     = 1'b0;
        w_timer   = (r_state == S_IDLE || w_tick) ? '0 : r_timer + BAUD_W'(1);

        case (r_state)
            S_IDLE: begin
                w_tx = 1'b1;
                if (r_count != '0) w_start = 1'b1;
            end
            S_START: begin
                if (w_tick) begin
                    w_state = S_DATA;
                    w_bit   = '0;
                    w_tx    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit == c_LAST_BIT) begin
                        w_bit = '0;
                        if (r_par_en) begin
                            w_state = S_PARITY;
                            w_tx    = r_par_bit;
                        end else begin
                            w_state = S_STOP;
                            w_tx    = 1'b1;
                        end
                    end else begin
                        w_bit   = r_bit + 4'd1;
                        w_shift = r_shift >> 1;
                        w_tx    = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state = S_STOP;
                    w_bit   = '0;
                    w_tx    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_bit == {2'b00, r_nstop - 2'd1}) begin
                        if (r_count != '0) begin
                            w_start = 1'b1;
                        end else begin
                            w_state = S_IDLE;
                            w_tx    = 1'b1;
                        end
                    end else begin
                        w_bit = r_bit + 4'd1;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Frame start: pop the head word and latch the line configuration.
        if (w_start) begin
            w_pop     = 1'b1;
            w_state   = S_START;
            w_timer   = '0;
            w_shift   = w_head;
            w_bmax    = (baudrate == '0) ? '0 : baudrate - BAUD_W'(1);
            w_nstop   = (stop == 2'd0) ? 2'd1 : stop;
            w_par_en  = parity_en;
            w_par_bit = (^w_head) ^ parity_odd;
            w_tx      = 1'b0;
        end

        w_count = r_count + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
        w_busy  = (w_state != S_IDLE) || (w_count != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_req_ack <= 1'b0;
            r_shift   <= '0;
            r_timer   <= '0;
            r_bmax    <= '0;
            r_bit     <= '0;
            r_nstop   <= 2'd1;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_wr_ptr  <= w_push ? r_wr_ptr + c_AW'(1) : r_wr_ptr;
            r_rd_ptr  <= w_pop  ? r_rd_ptr + c_AW'(1) : r_rd_ptr;
            r_count   <= w_count;
            r_req_ack <= w_push;
            r_shift   <= w_shift;
            r_timer   <= w_timer;
            r_bmax    <= w_bmax;
            r_bit     <= w_bit;
            r_nstop   <= w_nstop;
            r_par_en  <= w_par_en;
            r_par_bit <= w_par_bit;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.tx_data;
    end

    assign bus.req_ack = r_req_ack;
    assign uart_tx     = r_tx;
    assign busy        = r_busy;
    assign count       = r_count;
endmodule
`default_nettype wire
